// File: rtl/morse_decode_controller_if.sv
// Bus between the Morse decode controller and its surroundings: the key,
// tick, mode and backspace inputs plus the character buffer and status
// outputs. The controller takes the slave view; the driver side the master.
interface morse_decode_controller_if;
    logic        en;
    logic        tick;
    logic        key_in;
    logic        backspace;
    logic [63:0] char_buf;
    logic [3:0]  char_cnt;
    logic [2:0]  cur_len;
    logic [4:0]  cur_code;
    logic        commit;
    logic        err;

    modport master (
        output en, tick, key_in, backspace,
        input  char_buf, char_cnt, cur_len, cur_code, commit, err
    );

    modport slave (
        input  en, tick, key_in, backspace,
        output char_buf, char_cnt, cur_len, cur_code, commit, err
    );
endinterface

// File: rtl/morse_decode_controller.sv
// Morse decode controller: times key presses against a prescaled slow tick,
// classifies each press as dot or dash, closes a character after a silence
// gap and keeps an 8-slot character buffer (slot 0 = newest). Slot format is
// {len[2:0], code[4:0]} with the newest symbol in code bit 0 (dot=0, dash=1).
module morse_decode_controller #(
    parameter logic [15:0] TICK_DIV  = 16'd1,
    parameter int          DOT_MAX   = 300,
    parameter int          GAP_TICKS = 700,
    parameter int          MAX_SYM   = 5
) (
    input  logic                       clk,
    input  logic                       rst,
    morse_decode_controller_if.slave   bus
);

    // Counter is just wide enough to hold GAP_TICKS and saturates at all-ones.
    localparam int            CW      = $clog2(GAP_TICKS + 1);
    localparam logic [CW-1:0] CNT_MAX = {CW{1'b1}};
    localparam logic [CW-1:0] GAP_LIM = CW'(GAP_TICKS);
    localparam logic [31:0]   DOT_LIM = 32'(DOT_MAX);
    localparam logic [2:0]    LEN_MAX = 3'(MAX_SYM);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        PRESS  = 2'd1,
        GAP    = 2'd2,
        COMMIT = 2'd3
    } state_t;

    state_t        state_reg, state_next;
    logic [CW-1:0] cnt_reg, cnt_next, cnt_inc;
    logic [2:0]    cur_len_reg, cur_len_next;
    logic [4:0]    cur_code_reg, cur_code_next;
    logic [7:0]    slot_reg [8];
    logic [7:0]    slot_next [8];
    logic [3:0]    char_cnt_reg, char_cnt_next;
    logic          commit_reg, commit_next;
    logic          err_reg, err_next;
    logic          bs_pend_reg, bs_pend_next;
    logic          key_reg, bs_reg;
    logic [15:0]   div_reg;

    logic tick_en;
    logic key_rise, key_fall, bs_rise, bs_act;
    logic sym;

    // Edges are taken against the previous registered level, so they act one
    // clock after the input changes.
    assign key_rise = bus.key_in & ~key_reg;
    assign key_fall = ~bus.key_in & key_reg;
    assign bs_rise  = bus.backspace & ~bs_reg;
    // A backspace that landed in COMMIT is replayed on the following cycle.
    assign bs_act   = bs_rise | bs_pend_reg;

    // Only every TICK_DIV-th tick pulse advances the press/gap counter.
    assign tick_en  = bus.tick && ((div_reg + 16'd1) >= TICK_DIV);
    assign cnt_inc  = (cnt_reg == CNT_MAX) ? cnt_reg : cnt_reg + CW'(1);
    // Press length strictly above DOT_MAX ticks is a dash.
    assign sym      = ({{(32-CW){1'b0}}, cnt_reg} > DOT_LIM);

    // Input level history and tick prescaler; these run regardless of mode so
    // a key already held when the decoder is enabled produces no rise.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            key_reg <= 1'b0;
            bs_reg  <= 1'b0;
            div_reg <= '0;
        end else begin
            key_reg <= bus.key_in;
            bs_reg  <= bus.backspace;
            if (bus.tick) begin
                div_reg <= tick_en ? 16'd0 : div_reg + 16'd1;
            end
        end
    end

    // State register and all controller storage.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg    <= IDLE;
            cnt_reg      <= '0;
            cur_len_reg  <= '0;
            cur_code_reg <= '0;
            char_cnt_reg <= '0;
            commit_reg   <= 1'b0;
            err_reg      <= 1'b0;
            bs_pend_reg  <= 1'b0;
            for (int i = 0; i < 8; i++) begin
                slot_reg[i] <= '0;
            end
        end else begin
            state_reg    <= state_next;
            cnt_reg      <= cnt_next;
            cur_len_reg  <= cur_len_next;
            cur_code_reg <= cur_code_next;
            char_cnt_reg <= char_cnt_next;
            commit_reg   <= commit_next;
            err_reg      <= err_next;
            bs_pend_reg  <= bs_pend_next;
            for (int i = 0; i < 8; i++) begin
                slot_reg[i] <= slot_next[i];
            end
        end
    end

    // Next-state, symbol accumulation, buffer shifting and pulse generation.
    always_comb begin
        state_next    = state_reg;
        cnt_next      = cnt_reg;
        cur_len_next  = cur_len_reg;
        cur_code_next = cur_code_reg;
        char_cnt_next = char_cnt_reg;
        commit_next   = 1'b0;
        err_next      = 1'b0;
        bs_pend_next  = 1'b0;
        slot_next     = slot_reg;

        if (!bus.en) begin
            // Encoder mode owns the key: drop any partial character, keep the buffer.
            state_next    = IDLE;
            cnt_next      = '0;
            cur_len_next  = '0;
            cur_code_next = '0;
        end else if (state_reg == COMMIT) begin
            slot_next[0] = {cur_len_reg, cur_code_reg};
            for (int i = 1; i < 8; i++) begin
                slot_next[i] = slot_reg[i-1];
            end
            char_cnt_next = (char_cnt_reg == 4'd8) ? 4'd8 : char_cnt_reg + 4'd1;
            commit_next   = 1'b1;
            cur_len_next  = '0;
            cur_code_next = '0;
            cnt_next      = '0;
            state_next    = IDLE;
            bs_pend_next  = bs_rise;
        end else if (bs_act) begin
            if (cur_len_reg != 3'd0) begin
                // Erase the character being keyed and wait for a fresh key rise.
                cur_len_next  = '0;
                cur_code_next = '0;
                cnt_next      = '0;
                state_next    = IDLE;
            end else if (char_cnt_reg != 4'd0) begin
                // Remove the newest stored character; older ones move toward slot 0.
                for (int i = 0; i < 7; i++) begin
                    slot_next[i] = slot_reg[i+1];
                end
                slot_next[7]  = '0;
                char_cnt_next = char_cnt_reg - 4'd1;
            end
            // A release coinciding with backspace loses its symbol.
            if (state_reg == PRESS && key_fall) begin
                cnt_next   = '0;
                state_next = IDLE;
            end
        end else begin
            case (state_reg)
                IDLE: begin
                    if (key_rise) begin
                        cnt_next   = '0;
                        state_next = PRESS;
                    end
                end
                PRESS: begin
                    if (key_fall) begin
                        cnt_next = '0;
                        if (cur_len_reg < LEN_MAX) begin
                            cur_code_next = {cur_code_reg[3:0], sym};
                            cur_len_next  = cur_len_reg + 3'd1;
                            state_next    = GAP;
                        end else begin
                            // One symbol too many: the whole character is thrown away.
                            err_next      = 1'b1;
                            cur_len_next  = '0;
                            cur_code_next = '0;
                            state_next    = IDLE;
                        end
                    end else if (tick_en) begin
                        cnt_next = cnt_inc;
                    end
                end
                GAP: begin
                    if (key_rise) begin
                        cnt_next   = '0;
                        state_next = PRESS;
                    end else if (tick_en) begin
                        cnt_next = cnt_inc;
                        if (cnt_inc >= GAP_LIM) begin
                            state_next = COMMIT;
                        end
                    end
                end
                default: begin
                    state_next = IDLE;
                end
            endcase
        end
    end

    // Flatten the slot array onto the 64-bit buffer output.
    genvar gi;
    generate
        for (gi = 0; gi < 8; gi++) begin : g_slot_out
            assign bus.char_buf[8*gi +: 8] = slot_reg[gi];
        end
    endgenerate

    assign bus.char_cnt = char_cnt_reg;
    assign bus.cur_len  = cur_len_reg;
    assign bus.cur_code = cur_code_reg;
    assign bus.commit   = commit_reg;
    assign bus.err      = err_reg;

endmodule
